// File: rtl/mem_test_pkg.sv
// mem_test_pkg: pattern mode encodings and engine FSM states
package mem_test_pkg;
  typedef enum logic [1:0] {MODE_ADDR, MODE_INV, MODE_CHECK, MODE_WALK} mode_e;
  typedef enum logic [1:0] {IDLE, WRITE, READ, FIN} state_e;
endpackage

// File: rtl/mem_test_engine_if.sv
// mem_test_engine_if: Avalon-MM bus between the test engine and memory
interface mem_test_engine_if #(parameter int DATA_W = 32, parameter int ADDR_W = 25);
  logic [ADDR_W-1:0]   avm_address;
  logic                avm_read;
  logic                avm_write;
  logic [DATA_W-1:0]   avm_writedata;
  logic [DATA_W/8-1:0] avm_byteenable;
  logic [DATA_W-1:0]   avm_readdata;
  logic                avm_readdatavalid;
  logic                avm_waitrequest;
  modport master (
    output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
    input  avm_readdata, avm_readdatavalid, avm_waitrequest
  );
  modport slave (
    input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
    output avm_readdata, avm_readdatavalid, avm_waitrequest
  );
endinterface

// File: rtl/mem_test_pattern.sv
// mem_test_pattern: combinational test data for an address under a pattern mode
module mem_test_pattern
  import mem_test_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 25
) (
  input  logic [ADDR_W-1:0] addr,
  input  mode_e             mode,
  output logic [DATA_W-1:0] data
);
  logic [DATA_W-1:0] raw, one;
  logic [ADDR_W-1:0] bit_pos;
  always_comb begin
    raw     = DATA_W'(addr);
    bit_pos = addr % ADDR_W'(DATA_W);
    one     = {{(DATA_W-1){1'b0}}, 1'b1} << bit_pos;
    data    = mode == MODE_ADDR  ? raw :
              mode == MODE_INV   ? ~raw :
              mode == MODE_CHECK ? (addr[0] ? {(DATA_W/8){8'h55}} : {(DATA_W/8){8'hAA}}) :
                                   one;
  end
endmodule

// File: rtl/mem_test_engine.sv
// mem_test_engine: writes a pattern over an address range, reads it back with
// pipelined reads and counts mismatches.
module mem_test_engine
  import mem_test_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 25,
  parameter int MAX_PENDING = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  mem_test_engine_if.master bus
);
  localparam logic [3:0] MAXP = 4'(MAX_PENDING);
  state_e            state, nxt;
  mode_e             mode_r;
  logic [ADDR_W-1:0] base_r, len_r, cnt, exp_cnt, exp_addr;
  logic [3:0]        pending;
  logic [DATA_W-1:0] wr_pat, exp_pat;
  logic              wr_acc, rd_acc, rdv;
  assign exp_addr           = base_r + exp_cnt;
  assign bus.avm_address    = base_r + cnt;
  assign bus.avm_writedata  = wr_pat;
  assign bus.avm_byteenable = '1;
  assign wr_acc = bus.avm_write & ~bus.avm_waitrequest;
  assign rd_acc = bus.avm_read & ~bus.avm_waitrequest;
  assign rdv    = (state == READ) & bus.avm_readdatavalid;
  mem_test_pattern #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_wr_pat (
    .addr(bus.avm_address), .mode(mode_r), .data(wr_pat)
  );
  mem_test_pattern #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_exp_pat (
    .addr(exp_addr), .mode(mode_r), .data(exp_pat)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt           = state;
    busy          = state != IDLE;
    done          = state == FIN;
    bus.avm_write = 1'b0;
    bus.avm_read  = 1'b0;
    unique case (state)
      IDLE:  if (start) nxt = (length == '0) ? FIN : WRITE;
      WRITE: begin
        bus.avm_write = 1'b1;
        if (!bus.avm_waitrequest && cnt == len_r - ADDR_W'(1)) nxt = READ;
      end
      READ: begin
        bus.avm_read = (cnt != len_r) && (pending < MAXP);
        if (cnt == len_r && pending == '0) nxt = FIN;
      end
      FIN:   nxt = IDLE;
    endcase
  end
  // cnt is reused: write issue count in WRITE, read issue count in READ
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      mode_r         <= MODE_ADDR;
      base_r         <= '0;
      len_r          <= '0;
      cnt            <= '0;
      exp_cnt        <= '0;
      pending        <= '0;
      err_count      <= '0;
      first_err_addr <= '0;
      pass           <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        mode_r    <= mode_e'(mode);
        base_r    <= base_addr;
        len_r     <= length;
        cnt       <= '0;
        exp_cnt   <= '0;
        pending   <= '0;
        err_count <= '0;
        pass      <= 1'b0;
      end
      if (wr_acc) cnt <= (cnt == len_r - ADDR_W'(1)) ? '0 : cnt + 1'b1;
      if (rd_acc) cnt <= cnt + 1'b1;
      if (rd_acc != rdv) pending <= rd_acc ? pending + 1'b1 : pending - 1'b1;
      if (rdv) begin
        exp_cnt <= exp_cnt + 1'b1;
        if (bus.avm_readdata != exp_pat) begin
          if (err_count == '0) first_err_addr <= exp_addr;
          if (err_count != 16'hFFFF) err_count <= err_count + 1'b1;
        end
      end
      if (state == FIN) pass <= err_count == '0;
    end
endmodule

// File: tb/tb_mem_test_engine.sv
// tb_mem_test_engine: directed tests of mem_test_engine against an Avalon memory model
module tb_mem_test_engine;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [24:0] base_addr = '0;
  logic [24:0] length = '0;
  logic        busy, done, pass;
  logic [15:0] err_count;
  logic [24:0] first_err_addr;
  int total = 0;
  int bad = 0;
  mem_test_engine_if #(.DATA_W(32), .ADDR_W(25)) bus ();
  mem_test_engine #(.DATA_W(32), .ADDR_W(25), .MAX_PENDING(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
    .base_addr(base_addr), .length(length), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count), .first_err_addr(first_err_addr),
    .bus(bus)
  );
  always #5 clk = ~clk;
  logic [31:0] mem [logic [24:0]];
  logic [31:0] q_data [$];
  int          q_due [$];
  logic [24:0] wr_log [$];
  int cyc = 0, last_due = 0, wait_pct = 0, lat_min = 1, lat_max = 1;
  int wr_cnt = 0, rd_cnt = 0, done_cnt = 0, both_cnt = 0, outstanding = 0, max_pend = 0;
  bit flip = 0;
  // Memory model: decides waitrequest and returns read data in order mid-cycle
  always @(negedge clk) begin
    logic [31:0] d;
    int due;
    cyc++;
    if (!reset_n) begin
      q_data.delete();
      q_due.delete();
      outstanding = 0;
      bus.avm_readdatavalid = 1'b0;
      bus.avm_waitrequest = 1'b0;
      bus.avm_readdata = '0;
    end else begin
      if (bus.avm_read && bus.avm_write) both_cnt++;
      if (done) done_cnt++;
      bus.avm_waitrequest = ($urandom_range(99) < wait_pct);
      if (!bus.avm_waitrequest && bus.avm_write) begin
        mem[bus.avm_address] = bus.avm_writedata;
        wr_cnt++;
        wr_log.push_back(bus.avm_address);
      end
      if (!bus.avm_waitrequest && bus.avm_read) begin
        d = mem.exists(bus.avm_address) ? mem[bus.avm_address] : 32'h0;
        if (flip && (bus.avm_address == 25'h105 || bus.avm_address == 25'h10A)) d[3] = ~d[3];
        due = cyc + $urandom_range(lat_max, lat_min);
        if (q_due.size() != 0 && due <= last_due) due = last_due + 1;
        last_due = due;
        q_data.push_back(d);
        q_due.push_back(due);
        rd_cnt++;
        outstanding++;
      end
      bus.avm_readdatavalid = 1'b0;
      if (q_due.size() != 0 && q_due[0] <= cyc) begin
        bus.avm_readdata = q_data.pop_front();
        void'(q_due.pop_front());
        bus.avm_readdatavalid = 1'b1;
        outstanding--;
      end
      if (outstanding > max_pend) max_pend = outstanding;
    end
  end
  task automatic clear_stats();
    wr_cnt = 0; rd_cnt = 0; done_cnt = 0; both_cnt = 0; max_pend = 0;
    wr_log.delete();
  endtask
  task automatic run(input logic [1:0] m, input logic [24:0] b, input logic [24:0] l);
    int n;
    @(negedge clk);
    clear_stats();
    mode = m; base_addr = b; length = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (busy) begin
      bad++;
      $display("FAIL run_timeout busy=%0b required=0", busy);
    end
    repeat (2) @(negedge clk);
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    total += 10;
    if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b exp=0", busy); end
    if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%0b exp=0", done); end
    if (pass !== 1'b0) begin bad++; $display("FAIL rst_pass got=%0b exp=0", pass); end
    if (err_count !== 16'h0) begin bad++; $display("FAIL rst_err got=%h exp=0", err_count); end
    if (first_err_addr !== 25'h0) begin bad++; $display("FAIL rst_first got=%h exp=0", first_err_addr); end
    if (bus.avm_read !== 1'b0) begin bad++; $display("FAIL rst_read got=%0b exp=0", bus.avm_read); end
    if (bus.avm_write !== 1'b0) begin bad++; $display("FAIL rst_write got=%0b exp=0", bus.avm_write); end
    if (bus.avm_address !== 25'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", bus.avm_address); end
    if (bus.avm_writedata !== 32'h0) begin bad++; $display("FAIL rst_wdata got=%h exp=0", bus.avm_writedata); end
    if (bus.avm_byteenable !== 4'hF) begin bad++; $display("FAIL rst_be got=%h exp=f", bus.avm_byteenable); end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask
  task automatic test_basic();
    wait_pct = 0; lat_min = 1; lat_max = 1; flip = 0;
    run(2'b00, 25'h100, 25'd16);
    total += 7;
    if (wr_cnt != 16) begin bad++; $display("FAIL basic_writes got=%0d exp=16", wr_cnt); end
    if (rd_cnt != 16) begin bad++; $display("FAIL basic_reads got=%0d exp=16", rd_cnt); end
    if (done_cnt != 1) begin bad++; $display("FAIL basic_done got=%0d exp=1", done_cnt); end
    if (pass !== 1'b1) begin bad++; $display("FAIL basic_pass got=%0b exp=1", pass); end
    if (err_count !== 16'h0) begin bad++; $display("FAIL basic_err got=%h exp=0", err_count); end
    if (mem[25'h105] !== 32'h0000_0105) begin bad++; $display("FAIL basic_data got=%h exp=00000105", mem[25'h105]); end
    if (wr_log[0] !== 25'h100) begin bad++; $display("FAIL basic_first_addr got=%h exp=100", wr_log[0]); end
  endtask
  task automatic test_random();
    wait_pct = 30; lat_min = 1; lat_max = 8; flip = 0;
    run(2'b11, 25'h200, 25'd64);
    total += 6;
    if (max_pend > 4) begin bad++; $display("FAIL rand_pending got=%0d max=4", max_pend); end
    if (pass !== 1'b1) begin bad++; $display("FAIL rand_pass got=%0b exp=1", pass); end
    if (rd_cnt != 64) begin bad++; $display("FAIL rand_reads got=%0d exp=64", rd_cnt); end
    if (done_cnt != 1) begin bad++; $display("FAIL rand_done got=%0d exp=1", done_cnt); end
    if (both_cnt != 0) begin bad++; $display("FAIL rand_rd_and_wr got=%0d exp=0", both_cnt); end
    if (mem[25'h21F] !== 32'h8000_0000) begin bad++; $display("FAIL rand_walk got=%h exp=80000000", mem[25'h21F]); end
  endtask
  task automatic test_errors();
    wait_pct = 0; lat_min = 2; lat_max = 4; flip = 1;
    run(2'b01, 25'h100, 25'd16);
    flip = 0;
    total += 4;
    if (err_count !== 16'd2) begin bad++; $display("FAIL err_count got=%0d exp=2", err_count); end
    if (first_err_addr !== 25'h105) begin bad++; $display("FAIL err_first got=%h exp=105", first_err_addr); end
    if (pass !== 1'b0) begin bad++; $display("FAIL err_pass got=%0b exp=0", pass); end
    if (mem[25'h105] !== 32'hFFFF_FEFA) begin bad++; $display("FAIL err_inv_data got=%h exp=fffffefa", mem[25'h105]); end
  endtask
  task automatic test_zero();
    logic [24:0] exp_a [4];
    @(negedge clk);
    clear_stats();
    mode = 2'b00; base_addr = 25'h40; length = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total += 2;
    if (done !== 1'b1) begin bad++; $display("FAIL zero_done got=%0b exp=1", done); end
    if (busy !== 1'b1) begin bad++; $display("FAIL zero_busy got=%0b exp=1", busy); end
    @(negedge clk);
    total += 5;
    if (done !== 1'b0) begin bad++; $display("FAIL zero_done_end got=%0b exp=0", done); end
    if (busy !== 1'b0) begin bad++; $display("FAIL zero_idle got=%0b exp=0", busy); end
    if (pass !== 1'b1) begin bad++; $display("FAIL zero_pass got=%0b exp=1", pass); end
    if (err_count !== 16'h0) begin bad++; $display("FAIL zero_err got=%0d exp=0", err_count); end
    if (wr_cnt + rd_cnt != 0) begin bad++; $display("FAIL zero_bus got=%0d exp=0", wr_cnt + rd_cnt); end
    exp_a = '{25'h1FFFFFE, 25'h1FFFFFF, 25'h0, 25'h1};
    wait_pct = 20; lat_min = 1; lat_max = 3;
    run(2'b10, 25'h1FFFFFE, 25'd4);
    total += 4;
    if (wr_log.size() != 4) begin bad++; $display("FAIL wrap_count got=%0d exp=4", wr_log.size()); end
    else for (int i = 0; i < 4; i++)
      if (wr_log[i] !== exp_a[i]) begin bad++; $display("FAIL wrap_addr%0d got=%h exp=%h", i, wr_log[i], exp_a[i]); end
    total += 3;
    if (mem[25'h0] !== 32'hAAAA_AAAA) begin bad++; $display("FAIL wrap_even got=%h exp=aaaaaaaa", mem[25'h0]); end
    if (mem[25'h1FFFFFF] !== 32'h5555_5555) begin bad++; $display("FAIL wrap_odd got=%h exp=55555555", mem[25'h1FFFFFF]); end
    if (pass !== 1'b1) begin bad++; $display("FAIL wrap_pass got=%0b exp=1", pass); end
  endtask
  task automatic test_mid_reset();
    int n;
    wait_pct = 0; lat_min = 8; lat_max = 8;
    @(negedge clk);
    clear_stats();
    mode = 2'b00; base_addr = 25'h300; length = 25'd64; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!bus.avm_read && n < 500) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    total++;
    if (bus.avm_read !== 1'b1) begin bad++; $display("FAIL mid_in_read got=%0b exp=1", bus.avm_read); end
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    total += 2;
    if (bus.avm_read !== 1'b0) begin bad++; $display("FAIL mid_read got=%0b exp=0", bus.avm_read); end
    if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%0b exp=0", busy); end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    total += 2;
    if (done_cnt != 0) begin bad++; $display("FAIL mid_no_done got=%0d exp=0", done_cnt); end
    if (busy !== 1'b0) begin bad++; $display("FAIL mid_idle got=%0b exp=0", busy); end
    lat_min = 1; lat_max = 3;
    run(2'b00, 25'h100, 25'd16);
    total += 3;
    if (pass !== 1'b1) begin bad++; $display("FAIL mid_rerun_pass got=%0b exp=1", pass); end
    if (done_cnt != 1) begin bad++; $display("FAIL mid_rerun_done got=%0d exp=1", done_cnt); end
    if (rd_cnt != 16) begin bad++; $display("FAIL mid_rerun_reads got=%0d exp=16", rd_cnt); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_random();
    test_errors();
    test_zero();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
